key_debounce_pulse: RTL and testbench

//  Front-end conditioning for the board push-buttons (KEY[3:0], active-low, asynchronous, bouncing).

---
 rtl/seg7_pkg.sv | 11 +
 rtl/key_debounce_ch.sv | 100 ++++++++++
 rtl/key_debounce_pulse.sv | 46 ++++
 tb/tb_key_debounce_pulse.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seg7 board front-end.
// Clock-derived timing defaults for key conditioning.
package seg7_pkg;

  localparam int N_KEYS_DEFAULT = 4;
  localparam int CLK_HZ         = 125_000_000;
  localparam int DEBOUNCE_10MS  = CLK_HZ / 100;
  localparam int REPEAT_500MS   = CLK_HZ / 2;
  localparam int REPEAT_100MS   = CLK_HZ / 10;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF sync, debounce counter, level, strobes.
// Auto-repeat strobes only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_ch
  import seg7_pkg::*;
#(
`ifdef KEY_AUTOREPEAT_EN
  parameter int REPEAT_DELAY    = REPEAT_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_100MS,
`endif
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic CLOCK_125_p,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             rep_fire;

  assign s      = ~sync2;
  assign accept = (s != key_level) && (cnt == CNT_LAST);

  // Two-flop synchroniser; resets to released.
  always_ff @(posedge CLOCK_125_p) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Debounce counter, accepted level and registered strobes.
  always_ff @(posedge CLOCK_125_p) begin
    if (rst) begin
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= rep_fire;
      key_release <= 1'b0;
      if (s == key_level) begin
        cnt <= '0;
      end else if (accept) begin
        cnt         <= '0;
        key_level   <= s;
        key_press   <= s;
        key_release <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] R_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_RELOAD =
    RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RW-1:0] rcnt;

  // Repeat fires only while held; an accepted release wins.
  always_comb begin
    rep_fire = 1'b0;
    if (key_level && !accept && (rcnt == R_LAST))
      rep_fire = 1'b1;
  end

  // Repeat counter runs while the debounced level is high.
  always_ff @(posedge CLOCK_125_p) begin
    if (rst || !key_level || accept) begin
      rcnt <= '0;
    end else if (rep_fire) begin
      rcnt <= R_RELOAD;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end
`else
  // No auto-repeat: one press strobe per accepted press.
  always_comb begin
    rep_fire = 1'b0;
  end
`endif

endmodule

// File: rtl/key_debounce_pulse.sv
// Push-button conditioning: N independent debounced key channels.
// Optional auto-repeat via macro KEY_AUTOREPEAT_EN.
module key_debounce_pulse
  import seg7_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY    = REPEAT_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_100MS
) (
  input  logic              CLOCK_125_p,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 2");
  end

  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY)
  begin : g_bad_rep
    $error("need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
  end

  // One self-contained channel per key.
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
`ifdef KEY_AUTOREPEAT_EN
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .CLOCK_125_p (CLOCK_125_p),
      .rst         (rst),
      .key_n       (key_n[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse (DEBOUNCE_CYCLES=8).
// Repeat checks active when KEY_AUTOREPEAT_EN is defined.
module tb_key_debounce_pulse;

  logic       CLOCK_125_p = 1'b0;
  logic       rst;
  logic [3:0] key_n;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;

  int errs   = 0;
  int checks = 0;

  key_debounce_pulse #(
    .N_KEYS          (4),
    .DEBOUNCE_CYCLES (8),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (5)
  ) dut (
    .CLOCK_125_p (CLOCK_125_p),
    .rst         (rst),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

  always #4 CLOCK_125_p = ~CLOCK_125_p;

  task automatic check(input string tag,
                       input logic [3:0] got,
                       input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_125_p);
    #1;
  endtask

  initial begin
    logic [3:0] ep;

    // 1: reset, then idle with keys released
    rst   = 1'b1;
    key_n = 4'hF;
    repeat (3) tick();
    check("rst_level", key_level, 4'h0);
    check("rst_press", key_press, 4'h0);
    check("rst_rel", key_release, 4'h0);
    rst = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      check("idle", key_level | key_press | key_release, 4'h0);
    end

    // 2: press key 0
    key_n = 4'hE;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("p0_press", key_press, (k == 10) ? 4'h1 : 4'h0);
      check("p0_level", key_level, (k >= 10) ? 4'h1 : 4'h0);
    end

    // 3: key 1 bounces with 3-cycle runs, ends released
    for (int i = 0; i < 40; i++) begin
      key_n[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      check("b1_press", key_press, 4'h0);
      check("b1_level", key_level, 4'h1);
    end
    key_n[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("b1_settle", key_press, (k == 10) ? 4'h2 : 4'h0);
      check("b1_slevel", key_level, (k >= 10) ? 4'h3 : 4'h1);
    end

    // 4: release key 0
    key_n[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("r0_rel", key_release, (k == 10) ? 4'h1 : 4'h0);
      check("r0_press", key_press, 4'h0);
      check("r0_level", key_level, (k >= 10) ? 4'h2 : 4'h3);
    end

    // 5: release key 1, then press 3:2 and reset mid-count
    key_n = 4'hF;
    repeat (12) tick();
    check("r1_level", key_level, 4'h0);
    key_n = 4'h3;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("pre_rst", key_press | key_level, 4'h0);
    end
    rst = 1'b1;
    tick();
    check("mid_rst", key_level | key_press | key_release, 4'h0);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("p32_press", key_press, (k == 10) ? 4'hC : 4'h0);
      check("p32_level", key_level, (k >= 10) ? 4'hC : 4'h0);
    end

    // 6: release all, then hold key 2 for 60 cycles
    key_n = 4'hF;
    repeat (12) tick();
    check("r32_level", key_level, 4'h0);
    key_n = 4'hB;
    for (int k = 1; k <= 60; k++) begin
      tick();
      ep = (k == 10) ? 4'h4 : 4'h0;
`ifdef KEY_AUTOREPEAT_EN
      if (k >= 30 && ((k - 30) % 5) == 0) ep = 4'h4;
`endif
      check("h2_press", key_press, ep);
    end
    key_n = 4'hF;
    for (int k = 61; k <= 75; k++) begin
      tick();
      ep = 4'h0;
`ifdef KEY_AUTOREPEAT_EN
      if (k == 65) ep = 4'h4;
`endif
      check("h2_rpress", key_press, ep);
      check("h2_rel", key_release, (k == 70) ? 4'h4 : 4'h0);
    end
    repeat (25) begin
      tick();
      check("h2_quiet", key_press | key_level, 4'h0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
